// File: rtl/mem_master.sv
// Splits or assembles one 64-bit word as eight big-endian byte accesses on a byte-serial RAM port.
// Latency is 9 cycles for a write, 10 for a read and 1 for a range error; req_ready is high only in IDLE.
module mem_master #(
  parameter int unsigned mem_size = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        bus_en,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(mem_size);

  state_t      state;
  logic [2:0]  idx;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] acc;

  logic [64:0] last_byte;
  logic        in_range;
  logic [2:0]  idx_nx;
  logic [63:0] next_addr;
  logic [63:0] acc_shift;

  // The 65-bit sum keeps addresses near 2^64 from wrapping back into range.
  assign last_byte = {1'b0, req_addr} + 65'd7;
  assign in_range  = last_byte < MEM_LIMIT;
  assign idx_nx    = idx + 3'd1;
  assign next_addr = addr_q + {61'd0, idx_nx};
  assign acc_shift = {acc[55:0], bus_rdata};

  assign req_ready = reset && (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      acc       <= 64'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_error <= 1'b0;
      bus_en    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 64'd0;
      bus_wdata <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx     <= 3'd0;
            acc     <= 64'd0;
            if (!in_range) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= 64'd0;
            end else begin
              state     <= req_write ? WRITE : READ;
              bus_en    <= 1'b1;
              bus_we    <= req_write;
              bus_addr  <= req_addr;
              bus_wdata <= req_write ? req_wdata[63:56] : 8'd0;
            end
          end
        end

        WRITE: begin
          if (idx == 3'd7) begin
            state     <= RESP;
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 64'd0;
            bus_wdata <= 8'd0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= 64'd0;
          end else begin
            // wdata_q shifts left so the next byte to send always sits at [55:48].
            idx       <= idx_nx;
            bus_addr  <= next_addr;
            bus_wdata <= wdata_q[55:48];
            wdata_q   <= {wdata_q[55:0], 8'd0};
          end
        end

        READ: begin
          // Byte idx-1 returns while byte idx is being requested.
          if (idx != 3'd0) acc <= acc_shift;
          if (idx == 3'd7) begin
            state    <= DRAIN;
            bus_en   <= 1'b0;
            bus_addr <= 64'd0;
          end else begin
            idx      <= idx_nx;
            bus_addr <= next_addr;
          end
        end

        DRAIN: begin
          state     <= RESP;
          acc       <= acc_shift;
          rsp_valid <= 1'b1;
          rsp_error <= 1'b0;
          rsp_rdata <= acc_shift;
        end

        RESP: begin
          state     <= IDLE;
          idx       <= 3'd0;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= 64'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: vector table of word accesses against a byte RAM model,
// plus hand-written busy-hold and mid-write reset sequences.
module tb_mem_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        bus_en;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_master #(.mem_size(2048)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .bus_en    (bus_en),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clock = ~clock;

  // Byte RAM with one-cycle read latency; not affected by the DUT reset.
  logic [7:0] ram [0:2047];
  logic [7:0] rd_q;
  logic       ram_clr = 1'b1;

  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 8'd0;
    end else if (bus_en && bus_we) begin
      ram[bus_addr[10:0]] <= bus_wdata;
    end
    if (bus_en && !bus_we) rd_q <= ram[bus_addr[10:0]];
  end
  assign bus_rdata = rd_q;

  typedef struct {
    string       name;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) break;
      @(negedge clock);
    end
    check({name, "_ready_timeout"}, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic run_req(input vec_t v);
    int          lat;
    int          bus_cnt;
    logic        addr_ok;
    logic [63:0] obs;
    logic        got_err;
    logic [63:0] got_data;
    wait_ready(v.name);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    lat = 0; bus_cnt = 0; addr_ok = 1'b1; obs = 64'd0; got_err = 1'b0; got_data = 64'd0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) req_valid = 1'b0;
      if (bus_en) begin
        if (bus_addr !== v.addr + 64'(bus_cnt) || bus_we !== v.wr) addr_ok = 1'b0;
        obs = {obs[55:0], bus_wdata};
        bus_cnt++;
      end
      if (rsp_valid) begin
        lat = n;
        got_err = rsp_error;
        got_data = rsp_rdata;
        break;
      end
    end
    check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    check({v.name, "_rsp_error"}, {63'd0, got_err}, {63'd0, v.err});
    check({v.name, "_rsp_rdata"}, got_data, v.rdata);
    check({v.name, "_bus_cycles"}, 64'(bus_cnt), v.err ? 64'd0 : 64'd8);
    check({v.name, "_bus_addr_seq"}, {63'd0, addr_ok}, 64'd1);
    if (v.wr && !v.err) check({v.name, "_bus_wdata"}, obs, v.wdata);
    @(negedge clock);
    check({v.name, "_rsp_pulse"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    int          busy_ready;
    int          rsp_cnt;
    int          rsp1_n;
    int          rsp2_n;
    logic [63:0] rsp1_d;
    logic [63:0] rsp2_d;
    int          stray;
    vec_t        v;

    vecs[0] = '{"wr_0x10",     1'b1, 64'h10,                 64'h0123456789ABCDEF, 1'b0, 64'd0,                 9};
    vecs[1] = '{"rd_0x10",     1'b0, 64'h10,                 64'd0,                1'b0, 64'h0123456789ABCDEF, 10};
    vecs[2] = '{"wr_2040",     1'b1, 64'd2040,               64'hDEADBEEFCAFEF00D, 1'b0, 64'd0,                 9};
    vecs[3] = '{"rd_2040",     1'b0, 64'd2040,               64'd0,                1'b0, 64'hDEADBEEFCAFEF00D, 10};
    vecs[4] = '{"wr_2041",     1'b1, 64'd2041,               64'h1111111111111111, 1'b1, 64'd0,                 1};
    vecs[5] = '{"rd_2041",     1'b0, 64'd2041,               64'd0,                1'b1, 64'd0,                 1};
    vecs[6] = '{"rd_wrap_fc",  1'b0, 64'hFFFFFFFFFFFFFFFC,   64'd0,                1'b1, 64'd0,                 1};
    vecs[7] = '{"wr_wrap_f9",  1'b1, 64'hFFFFFFFFFFFFFFF9,   64'h2222222222222222, 1'b1, 64'd0,                 1};
    vecs[8] = '{"rd_0x14",     1'b0, 64'h14,                 64'd0,                1'b0, 64'h89ABCDEF00000000, 10};
    vecs[9] = '{"wr_0x20",     1'b1, 64'h20,                 64'h1122334455667788, 1'b0, 64'd0,                 9};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_bus_en", {63'd0, bus_en}, 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    ram_clr = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_req(vecs[i]);
    v = '{"rd_0x20", 1'b0, 64'h20, 64'd0, 1'b0, 64'h1122334455667788, 10};
    run_req(v);

    // Second request held on the port during a busy read
    wait_ready("busy");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_wdata = 64'd0;
    busy_ready = 0; rsp_cnt = 0; rsp1_n = 0; rsp2_n = 0; rsp1_d = 64'd0; rsp2_d = 64'd0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 1) req_addr = 64'h20;
      if (n <= 10 && req_ready) busy_ready++;
      if (n == 11) check("busy_ready_after_resp", {63'd0, req_ready}, 64'd1);
      if (n == 12) req_valid = 1'b0;
      if (rsp_valid) begin
        if (rsp_cnt == 0) begin rsp1_n = n; rsp1_d = rsp_rdata; end
        else begin rsp2_n = n; rsp2_d = rsp_rdata; end
        rsp_cnt++;
      end
    end
    check("busy_ready_low", 64'(busy_ready), 64'd0);
    check("busy_rsp_count", 64'(rsp_cnt), 64'd2);
    check("busy_rsp1_cycle", 64'(rsp1_n), 64'd10);
    check("busy_rsp1_data", rsp1_d, 64'h0123456789ABCDEF);
    check("busy_rsp2_cycle", 64'(rsp2_n), 64'd21);
    check("busy_rsp2_data", rsp2_d, 64'h1122334455667788);

    // Reset after the fourth write byte has landed
    wait_ready("abort");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h0123456789ABCDEF;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clock);
      if (n == 1) req_valid = 1'b0;
      if (n == 4) check("abort_4th_byte", {56'd0, bus_wdata}, 64'h67);
    end
    reset = 1'b0;
    #1;
    check("abort_bus_en", {63'd0, bus_en}, 64'd0);
    check("abort_bus_we", {63'd0, bus_we}, 64'd0);
    check("abort_bus_addr", bus_addr, 64'd0);
    check("abort_bus_wdata", {56'd0, bus_wdata}, 64'd0);
    check("abort_rsp", {62'd0, rsp_valid, rsp_error}, 64'd0);
    check("abort_rsp_rdata", rsp_rdata, 64'd0);
    check("abort_req_ready", {63'd0, req_ready}, 64'd0);
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid) stray++;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clock);
      if (rsp_valid) stray++;
    end
    check("abort_no_rsp", 64'(stray), 64'd0);
    v = '{"rd_after_abort", 1'b0, 64'h20, 64'd0, 1'b0, 64'h0123456755667788, 10};
    run_req(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_master.md
# mem_master

Memory-stage initiator for the SEQ datapath. It turns one 8-byte word read or write into eight byte-wide accesses on a byte-serial RAM port, assembling or splitting the word in big-endian order (lowest address = most significant byte). It sits between the memory stage (address valE, data valA) and a byte-wide data RAM. It performs the `mem_size` bounds check itself and reports violations as `rsp_error` without touching the bus.

## Interface
- `mem_size`, default 2048: RAM size in bytes; a word access at `addr` is legal iff `addr + 7 < mem_size`.
- `clock`  in  1: single clock, all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; 0 forces the reset state immediately.
- `req_valid`  in  1: CPU request present.
- `req_ready`  out  1: block can accept a request; 1 only in IDLE.
- `req_write`  in  1: 1 = write word, 0 = read word.
- `req_addr`  in  64: byte address of the word.
- `req_wdata`  in  64: write data.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  64: read word on read completion, 0 otherwise.
- `rsp_error`  out  1: qualifies `rsp_valid`; 1 = out-of-range access, nothing issued.
- `bus_en`  out  1: byte access strobe.
- `bus_we`  out  1: 1 = byte write, 0 = byte read; meaningful only with `bus_en`.
- `bus_addr`  out  64: byte address.
- `bus_wdata`  out  8: write byte.
- `bus_rdata`  in  8: read byte; data for a read issued in cycle N is valid in cycle N+1.

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_write`, `req_addr`, and `req_wdata`.
  - Bounds check uses a 65-bit sum (`req_addr + 7`), so addresses near 2^64 cannot wrap into range.
  - Out of range: go to RESP with error set.
  - In range: go to WRITE if `req_write` is 1, otherwise READ.
  - Byte counter `idx` is cleared.
- WRITE: drive `bus_en`=1, `bus_we`=1, `bus_addr`=addr+idx, `bus_wdata`=byte idx of the latched word (idx 0 = bits 63:56). Increment `idx`. After idx=7, go to RESP.
- READ: drive `bus_en`=1, `bus_we`=0, `bus_addr`=addr+idx. Each cycle after the first, shift the previous byte in: `acc` <= {`acc`[55:0], `bus_rdata`}. After idx=7, go to DRAIN.
- DRAIN: `bus_en`=0. Capture the eighth byte, then go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle.
  - `rsp_error` = latched error flag.
  - `rsp_rdata` = `acc` for a successful read, 0 for writes and errors.
  - Next state is IDLE.
- `idx` is 3 bits. Byte addresses are `addr`+0..7 computed in 64 bits; in-range requests never overflow.
- Requests presented while `req_ready`=0 are not accepted. The CPU holds `req_valid` and the payload until the accept cycle. Back-to-back requests are accepted in the IDLE cycle after RESP.
- Reset (asserted at any time, including mid-access):
  - state=IDLE, `idx`=0, `acc`=0.
  - Outputs: `req_ready`=1 once reset is released (0 during reset), `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `bus_en`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
  - Bytes already written stay written. No response is produced for the aborted request.

## Timing
- Accept cycle T (IDLE, `req_valid`=1); all bus outputs are registered.
- Write: bus cycles at T+1..T+8, `rsp_valid` at T+9. Latency 9, throughput one word per 10 cycles.
- Read: bus cycles at T+1..T+8, bytes arrive at T+2..T+9, `rsp_valid` with data at T+10. Latency 10.
- Error: no bus cycle; `rsp_valid`=`rsp_error`=1 at T+1.
- `bus_en`=0 in IDLE, DRAIN, and RESP.

## Test plan
- Write `req_addr`=0x10, `req_wdata`=0x0123456789ABCDEF → bus writes 0x01..0xEF to 0x10..0x17 in cycles T+1..T+8, `rsp_valid` at T+9 with `rsp_rdata`=0 and `rsp_error`=0.
- Read `req_addr`=0x10 after the previous write (behavioural byte RAM model, 1-cycle read) → `rsp_valid` at T+10, `rsp_rdata`=0x0123456789ABCDEF.
- Boundary with `mem_size`=2048:
  - `req_addr`=2040 → success.
  - `req_addr`=2041 → `rsp_error`=1 at T+1, `bus_en` never asserted.
  - `req_addr`=0xFFFFFFFFFFFFFFFC → error, with no wrap to a legal range.
- Hold `req_valid` with a new request during a busy read → `req_ready`=0 throughout. The second request is accepted in the IDLE cycle after RESP and completes with correct data.
- Assert reset after the 4th write byte (bytes 0x01..0x67 written) → all outputs 0 immediately. No `rsp_valid` for the aborted request. A subsequent read returns 0x01234567 followed by the prior memory contents.
